cv32e40px_alu_div_radix: RTL

- Parametrised iterative integer divider/remainder unit for the ALU's DIV/DIVU/REM/REMU path.
- Restoring division on operand magnitudes, producing C_RADIX_BITS quotient bits per cycle, with sign fix-up on output.
- Adds input ready/kill handshakes, back-to-back issue and RISC-V special-case results to the single-bit serial divider generation.
- Sits beside the ALU in EX and is driven by the ALU/ID stall logic.

---
 rtl/cv32e40px_alu_div_radix.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cv32e40px_alu_div_radix.sv
// Iterative restoring divider/remainder unit (DIV/DIVU/REM/REMU), C_RADIX_BITS quotient bits per cycle.
// Optional early-out for div-by-zero and |A| < |B| when CV32E40PX_DIV_FAST_PATH_EN is defined.
module cv32e40px_alu_div_radix #(
  parameter int unsigned C_WIDTH      = 32,
  parameter int unsigned C_RADIX_BITS = 1
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  input  logic [C_WIDTH-1:0] OpA_DI,
  input  logic [C_WIDTH-1:0] OpB_DI,
  input  logic [1:0]         OpCode_SI,
  input  logic               InVld_SI,
  output logic               InRdy_SO,
  input  logic               Kill_SI,
  output logic               OutVld_SO,
  input  logic               OutRdy_SI,
  output logic [C_WIDTH-1:0] Res_DO,
  output logic               Busy_SO
);

  localparam int unsigned C_ITER = C_WIDTH / C_RADIX_BITS;
  localparam int unsigned CNT_W  = (C_ITER > 1) ? $clog2(C_ITER) : 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

  state_e             state_q, state_d;
  logic [C_WIDTH-1:0] ra_q, ra_d;
  logic [C_WIDTH-1:0] rb_q, rb_d;
  logic [C_WIDTH-1:0] rem_q, rem_d;
  logic [C_WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rem_sel_q, rem_sel_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [C_WIDTH-1:0] res_q, res_d;

  logic               in_rdy_c;
  logic               accept_c;
  logic               op_signed_c;
  logic               div0_c;
  logic [C_WIDTH-1:0] mag_a_c;
  logic [C_WIDTH-1:0] mag_b_c;
  logic [C_WIDTH-1:0] ra_step_c;
  logic [C_WIDTH-1:0] rem_step_c;
  logic [C_WIDTH-1:0] quo_step_c;
  logic [C_WIDTH:0]   shifted_c;
  logic [C_WIDTH:0]   trial_c;
  logic [C_WIDTH-1:0] fin_res_c;

  assign in_rdy_c  = (state_q == IDLE) || ((state_q == FINISH) && OutRdy_SI);
  assign accept_c  = InVld_SI && in_rdy_c && !Kill_SI;
  assign InRdy_SO  = in_rdy_c;
  assign OutVld_SO = (state_q == FINISH);
  assign Busy_SO   = (state_q != IDLE);
  assign Res_DO    = res_q;

  // Operand magnitudes; |MIN_INT| is naturally 2^(C_WIDTH-1) as unsigned.
  assign op_signed_c = OpCode_SI[0];
  assign div0_c      = (OpB_DI == '0);
  assign mag_a_c     = (op_signed_c && OpA_DI[C_WIDTH-1]) ? (-OpA_DI) : OpA_DI;
  assign mag_b_c     = (op_signed_c && OpB_DI[C_WIDTH-1]) ? (-OpB_DI) : OpB_DI;

`ifdef CV32E40PX_DIV_FAST_PATH_EN
  logic               fast_c;
  logic [C_WIDTH-1:0] fast_res_c;
  logic               fast_neg_rem_c;

  assign fast_c         = div0_c || (mag_a_c < mag_b_c);
  assign fast_neg_rem_c = op_signed_c && OpA_DI[C_WIDTH-1];
  assign fast_res_c     = OpCode_SI[1] ? (fast_neg_rem_c ? (-mag_a_c) : mag_a_c)
                                       : {C_WIDTH{div0_c}};
`endif

  // C_RADIX_BITS restoring steps per cycle, MSB-first.
  always_comb begin
    ra_step_c  = ra_q;
    rem_step_c = rem_q;
    quo_step_c = quo_q;
    shifted_c  = '0;
    trial_c    = '0;
    for (int unsigned i = 0; i < C_RADIX_BITS; i++) begin
      shifted_c  = {rem_step_c, ra_step_c[C_WIDTH-1]};
      trial_c    = shifted_c - {1'b0, rb_q};
      ra_step_c  = {ra_step_c[C_WIDTH-2:0], 1'b0};
      rem_step_c = trial_c[C_WIDTH] ? shifted_c[C_WIDTH-1:0] : trial_c[C_WIDTH-1:0];
      quo_step_c = {quo_step_c[C_WIDTH-2:0], ~trial_c[C_WIDTH]};
    end
  end

  // Sign fix-up applied to the final step so Res_DO comes straight from a flop.
  always_comb begin
    fin_res_c = '0;
    if (rem_sel_q) fin_res_c = neg_rem_q ? (-rem_step_c) : rem_step_c;
    else           fin_res_c = neg_quo_q ? (-quo_step_c) : quo_step_c;
  end

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;

    case (state_q)
      IDLE: ;
      DIVIDE: begin
        ra_d  = ra_step_c;
        rem_d = rem_step_c;
        quo_d = quo_step_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = FINISH;
          res_d   = fin_res_c;
        end
      end
      FINISH: begin
        if (OutRdy_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      state_d   = DIVIDE;
      ra_d      = mag_a_c;
      rb_d      = mag_b_c;
      rem_d     = '0;
      quo_d     = '0;
      cnt_d     = CNT_W'(C_ITER - 1);
      rem_sel_d = OpCode_SI[1];
      neg_quo_d = op_signed_c && (OpA_DI[C_WIDTH-1] ^ OpB_DI[C_WIDTH-1]) && !div0_c;
      neg_rem_d = op_signed_c && OpA_DI[C_WIDTH-1];
`ifdef CV32E40PX_DIV_FAST_PATH_EN
      if (fast_c) begin
        state_d = FINISH;
        res_d   = fast_res_c;
      end
`endif
    end

    // Flush: abandon everything, keep the last delivered result.
    if (Kill_SI) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q   <= IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
    end
  end

endmodule
